// File: rtl/bus_xfer_pkg.sv
// Shared constants, bus command encodings and FSM states for bus_xfer_ctrl.
// Optional build macro XFER_RR_ARB_EN is consumed by bus_xfer_arb.
package bus_xfer_pkg;

    // Device select codes in AddrBus[31:28]
    localparam logic [3:0] DEV_MEM  = 4'h1;
    localparam logic [3:0] DEV_UART = 4'h2;

    // SRAM write-enable (active low) position in the memory command
    localparam int BWE_BIT = 18;

    // UART command bits in AddrBus[2:0]
    localparam logic [2:0] UART_LOAD  = 3'b001;
    localparam logic [2:0] UART_BRDY  = 3'b010;
    localparam logic [2:0] UART_TBYTE = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXT,
        S_RD,
        S_CAP,
        S_LD,
        S_BRDY,
        S_TBYTE,
        S_WAITU,
        S_NEXT
    } xfer_state_t;

    // Full 32-bit AddrBus word for a UART command
    function automatic logic [31:0] uart_cmd(input logic [2:0] bits);
        return {DEV_UART, 25'b0, bits};
    endfunction

endpackage

// File: rtl/bus_xfer_arb.sv
// Bus grant decision between the external master and the copy engine.
// With XFER_RR_ARB_EN defined, ties alternate; otherwise Breq always wins.
module bus_xfer_arb (
`ifdef XFER_RR_ARB_EN
    input  logic clk,
    input  logic Reset,
`endif
    input  logic breq,
    input  logic pending,
    input  logic decide,
    output logic grant_ext,
    output logic grant_xfer
);

`ifdef XFER_RR_ARB_EN
    // 1 when the external master owned the bus most recently
    logic last_ext;

    // On a tie the party that did not own the bus last wins
    always_comb begin
        grant_ext  = 1'b0;
        grant_xfer = 1'b0;
        if (decide) begin
            if (breq && pending) begin
                grant_ext  = !last_ext;
                grant_xfer = last_ext;
            end else begin
                grant_ext  = breq;
                grant_xfer = pending;
            end
        end
    end

    // Remember the owner of every grant; reset favours the external master
    always_ff @(posedge clk) begin
        if (Reset) begin
            last_ext <= 1'b0;
        end else if (grant_ext || grant_xfer) begin
            last_ext <= grant_ext;
        end
    end
`else
    // Fixed priority: the external master always wins
    always_comb begin
        grant_ext  = decide && breq;
        grant_xfer = decide && !breq && pending;
    end
`endif

endmodule

// File: rtl/bus_xfer_ctrl.sv
// SRAM-to-UART byte copy engine sharing a command bus with an external master.
// Define XFER_RR_ARB_EN for round-robin arbitration of bus ties.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int AddrSize  = 18,
    parameter int WordSize  = 8,
    parameter int CmdCycles = 3
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                Breq,
    output logic                Bgnt,
    input  logic                Xfer_start,
    input  logic [AddrSize-1:0] Xfer_addr,
    input  logic [7:0]          Xfer_len,
    output logic                Xfer_busy,
    output logic                Xfer_done,
    input  logic [WordSize-1:0] DataBus_in,
    output logic [WordSize-1:0] Data_out,
    output logic                Data_oe,
    output logic [31:0]         AddrBus_out,
    output logic                Addr_oe,
    input  logic                Uart_busy
);

    localparam int CW = $clog2(2 * CmdCycles + 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CmdCycles - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(2 * CmdCycles - 1);

    xfer_state_t         state;
    xfer_state_t         nxt;
    logic [CW-1:0]       cnt;
    logic [AddrSize-1:0] addr;
    logic [7:0]          count;
    logic [WordSize-1:0] byte_q;
    logic                seen;

    logic                grant_ext;
    logic                grant_xfer;
    logic                cnt_last;
    logic                wait_exit;
    logic [31:0]         rd_cmd;
    logic [WordSize-1:0] data_src;

    logic                bgnt_d;
    logic                aoe_d;
    logic [31:0]         abus_d;
    logic                doe_d;
    logic [WordSize-1:0] dout_d;

    bus_xfer_arb u_arb (
`ifdef XFER_RR_ARB_EN
        .clk        (clk),
        .Reset      (Reset),
`endif
        .breq       (Breq),
        .pending    (Xfer_busy),
        .decide     (state == S_IDLE),
        .grant_ext  (grant_ext),
        .grant_xfer (grant_xfer)
    );

    // SRAM read command for the current address, bWE held high
    always_comb begin
        rd_cmd                 = '0;
        rd_cmd[31:28]          = DEV_MEM;
        rd_cmd[BWE_BIT]        = 1'b1;
        rd_cmd[AddrSize-1:0]   = addr;
    end

    // Byte shown on LD entry comes straight from the bus being captured
    always_comb begin
        data_src = (state == S_CAP) ? DataBus_in : byte_q;
    end

    // Next-state decode; only IDLE consults the arbiter
    always_comb begin
        nxt       = state;
        cnt_last  = (cnt == CMD_LAST);
        wait_exit = !Uart_busy && (seen || cnt == WAIT_LAST);
        unique case (state)
            S_IDLE: begin
                if (grant_ext) begin
                    nxt = S_EXT;
                end else if (grant_xfer) begin
                    nxt = S_RD;
                end
            end
            S_EXT:   if (!Breq) nxt = S_IDLE;
            S_RD:    if (cnt_last) nxt = S_CAP;
            S_CAP:   nxt = S_LD;
            S_LD:    if (cnt_last) nxt = S_BRDY;
            S_BRDY:  if (cnt_last) nxt = S_TBYTE;
            S_TBYTE: if (cnt_last) nxt = S_WAITU;
            S_WAITU: if (wait_exit) nxt = S_NEXT;
            S_NEXT:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Bus outputs for the state being entered, registered below
    always_comb begin
        bgnt_d = 1'b0;
        aoe_d  = 1'b0;
        abus_d = '0;
        doe_d  = 1'b0;
        dout_d = '0;
        unique case (nxt)
            S_EXT: bgnt_d = 1'b1;
            S_RD, S_CAP: begin
                aoe_d  = 1'b1;
                abus_d = rd_cmd;
            end
            S_LD: begin
                aoe_d  = 1'b1;
                abus_d = uart_cmd(UART_LOAD);
                doe_d  = 1'b1;
                dout_d = data_src;
            end
            S_BRDY: begin
                aoe_d  = 1'b1;
                abus_d = uart_cmd(UART_BRDY);
                doe_d  = 1'b1;
                dout_d = data_src;
            end
            S_TBYTE: begin
                aoe_d  = 1'b1;
                abus_d = uart_cmd(UART_TBYTE);
                doe_d  = 1'b1;
                dout_d = data_src;
            end
            S_WAITU: aoe_d = 1'b1;
            default: ;
        endcase
    end

    // FSM state, copy bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr        <= '0;
            count       <= '0;
            byte_q      <= '0;
            seen        <= 1'b0;
            Bgnt        <= 1'b0;
            Xfer_busy   <= 1'b0;
            Xfer_done   <= 1'b0;
            Data_out    <= '0;
            Data_oe     <= 1'b0;
            AddrBus_out <= '0;
            Addr_oe     <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : cnt + 1'b1;
            seen        <= (state == S_WAITU) && (seen || Uart_busy);
            Bgnt        <= bgnt_d;
            Addr_oe     <= aoe_d;
            AddrBus_out <= abus_d;
            Data_oe     <= doe_d;
            Data_out    <= dout_d;
            Xfer_done   <= 1'b0;
            if (state == S_CAP) begin
                byte_q <= DataBus_in;
            end
            if (state == S_NEXT) begin
                addr  <= addr + 1'b1;
                count <= count - 8'd1;
                if (count == 8'd1) begin
                    Xfer_done <= 1'b1;
                    Xfer_busy <= 1'b0;
                end
            end else if (Xfer_start && !Xfer_busy) begin
                addr  <= Xfer_addr;
                count <= Xfer_len;
                if (Xfer_len == 8'd0) begin
                    Xfer_done <= 1'b1;
                end else begin
                    Xfer_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed self-checking bench for bus_xfer_ctrl.
// Honours XFER_RR_ARB_EN for the arbitration scenario.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Breq;
    logic        Bgnt;
    logic        Xfer_start;
    logic [17:0] Xfer_addr;
    logic [7:0]  Xfer_len;
    logic        Xfer_busy;
    logic        Xfer_done;
    logic [7:0]  DataBus_in;
    logic [7:0]  Data_out;
    logic        Data_oe;
    logic [31:0] AddrBus_out;
    logic        Addr_oe;
    logic        Uart_busy;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    // SRAM model: byte at address a is a[7:0] ^ 8'h05
    always_comb begin
        if (Addr_oe && AddrBus_out[31:28] == 4'h1)
            DataBus_in = AddrBus_out[7:0] ^ 8'h05;
        else
            DataBus_in = 8'h00;
    end

    always @(negedge clk) begin
        if (Xfer_done) done_cnt++;
        if (Bgnt && Addr_oe) overlap++;
    end

    bus_xfer_ctrl dut (
        .clk         (clk),
        .Reset       (Reset),
        .Breq        (Breq),
        .Bgnt        (Bgnt),
        .Xfer_start  (Xfer_start),
        .Xfer_addr   (Xfer_addr),
        .Xfer_len    (Xfer_len),
        .Xfer_busy   (Xfer_busy),
        .Xfer_done   (Xfer_done),
        .DataBus_in  (DataBus_in),
        .Data_out    (Data_out),
        .Data_oe     (Data_oe),
        .AddrBus_out (AddrBus_out),
        .Addr_oe     (Addr_oe),
        .Uart_busy   (Uart_busy)
    );

    task automatic test_reset;
        Reset = 1'b1;
        Breq = 1'b0;
        Xfer_start = 1'b0;
        Xfer_addr = '0;
        Xfer_len = '0;
        Uart_busy = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({Bgnt, Xfer_busy, Xfer_done, Data_oe, Addr_oe} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000",
                     {Bgnt, Xfer_busy, Xfer_done, Data_oe, Addr_oe});
        end
        total++;
        if (AddrBus_out !== 32'h0 || Data_out !== 8'h0) begin
            bad++;
            $display("FAIL reset_buses got=%h/%h want=0/0", AddrBus_out, Data_out);
        end
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (Bgnt !== 1'b0 || Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b%b want=00", Bgnt, Addr_oe);
        end
    endtask

    // One byte from 0x30 with full command sequence; second start is ignored
    task automatic test_basic;
        logic [31:0] ea;
        logic        eao;
        logic        edoe;
        int          d0;
        d0 = done_cnt;
        Xfer_addr = 18'h00030;
        Xfer_len = 8'd1;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        total++;
        if (Xfer_busy !== 1'b1 || Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL busy_rise got=%b%b want=10", Xfer_busy, Addr_oe);
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                ea = 32'h1004_0030; eao = 1'b1; edoe = 1'b0;
            end else if (i < 7) begin
                ea = 32'h2000_0001; eao = 1'b1; edoe = 1'b1;
            end else if (i < 10) begin
                ea = 32'h2000_0002; eao = 1'b1; edoe = 1'b1;
            end else if (i < 13) begin
                ea = 32'h2000_0004; eao = 1'b1; edoe = 1'b1;
            end else if (i < 19) begin
                ea = 32'h0; eao = 1'b1; edoe = 1'b0;
            end else begin
                ea = 32'h0; eao = 1'b0; edoe = 1'b0;
            end
            total++;
            if (AddrBus_out !== ea || Addr_oe !== eao || Data_oe !== edoe ||
                (edoe && Data_out !== 8'h35) || Xfer_done !== 1'b0) begin
                bad++;
                $display("FAIL basic_seq[%0d] got=%h oe=%b doe=%b d=%h want=%h oe=%b doe=%b d=35",
                         i, AddrBus_out, Addr_oe, Data_oe, Data_out, ea, eao, edoe);
            end
            Xfer_start = (i == 1);
            Xfer_addr = (i == 1) ? 18'h00055 : 18'h00030;
            Xfer_len = (i == 1) ? 8'd5 : 8'd1;
            @(negedge clk);
        end
        total++;
        if (Xfer_done !== 1'b1 || Xfer_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got=%b%b want=10", Xfer_done, Xfer_busy);
        end
        repeat (5) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 1 || Xfer_busy !== 1'b0 || Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL basic_once got=%0d busy=%b want=1 busy=0", done_cnt - d0, Xfer_busy);
        end
    endtask

    task automatic test_len0;
        int aoe_seen;
        aoe_seen = 0;
        Xfer_addr = 18'h00100;
        Xfer_len = 8'd0;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        total++;
        if (Xfer_done !== 1'b1 || Xfer_busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_done got=%b%b want=10", Xfer_done, Xfer_busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (Addr_oe) aoe_seen++;
            @(negedge clk);
        end
        total++;
        if (aoe_seen !== 0 || Xfer_done !== 1'b0) begin
            bad++;
            $display("FAIL len0_quiet got=%0d want=0", aoe_seen);
        end
    endtask

    // WAITU holds past the timeout while the UART is shifting
    task automatic test_uart_wait;
        bit ok;
        Xfer_addr = 18'h00020;
        Xfer_len = 8'd1;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (Addr_oe && AddrBus_out == 32'h0) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL waitu_reach got=timeout want=WAITU");
        end
        Uart_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (Addr_oe !== 1'b1 || AddrBus_out !== 32'h0) begin
                bad++;
                $display("FAIL waitu_hold[%0d] got=%b/%h want=1/0", i, Addr_oe, AddrBus_out);
            end
        end
        Uart_busy = 1'b0;
        @(negedge clk);
        total++;
        if (Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL waitu_release got=%b want=0", Addr_oe);
        end
        @(negedge clk);
        total++;
        if (Xfer_done !== 1'b1) begin
            bad++;
            $display("FAIL waitu_done got=%b want=1", Xfer_done);
        end
        @(negedge clk);
    endtask

    // Breq during byte 1 of 2: grant only at the byte boundary
    task automatic test_breq_boundary;
        int n;
        bit ok;
        Xfer_addr = 18'h00010;
        Xfer_len = 8'd2;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        @(negedge clk);
        Breq = 1'b1;
        n = 0;
        ok = 0;
        for (int i = 1; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (Bgnt) begin
                ok = 1;
                n = i;
            end
        end
        total++;
        if (!ok || n !== 21) begin
            bad++;
            $display("FAIL breq_grant_cycle got=%0d want=21", n);
        end
        repeat (4) @(negedge clk);
        total++;
        if (Bgnt !== 1'b1 || Addr_oe !== 1'b0 || Xfer_busy !== 1'b1) begin
            bad++;
            $display("FAIL breq_hold got=%b%b%b want=101", Bgnt, Addr_oe, Xfer_busy);
        end
        Breq = 1'b0;
        @(negedge clk);
        total++;
        if (Bgnt !== 1'b0 || Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL breq_release got=%b%b want=00", Bgnt, Addr_oe);
        end
        @(negedge clk);
        total++;
        if (Addr_oe !== 1'b1 || AddrBus_out !== 32'h1004_0011) begin
            bad++;
            $display("FAIL byte2_start got=%b/%h want=1/10040011", Addr_oe, AddrBus_out);
        end
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (Xfer_done) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL breq_done got=timeout want=done");
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        bit ok;
        Xfer_addr = 18'h3FFFF;
        Xfer_len = 8'd2;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        @(negedge clk);
        total++;
        if (AddrBus_out !== 32'h1007_FFFF) begin
            bad++;
            $display("FAIL wrap_rd1 got=%h want=1007ffff", AddrBus_out);
        end
        repeat (4) @(negedge clk);
        total++;
        if (Data_oe !== 1'b1 || Data_out !== 8'hFA) begin
            bad++;
            $display("FAIL wrap_data1 got=%b/%h want=1/fa", Data_oe, Data_out);
        end
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!Addr_oe) ok = 1;
        end
        for (int i = 0; i < 10 && ok; i++) begin
            @(negedge clk);
            if (Addr_oe) ok = 0;
        end
        total++;
        if (ok || AddrBus_out !== 32'h1004_0000) begin
            bad++;
            $display("FAIL wrap_rd2 got=%h want=10040000", AddrBus_out);
        end
        repeat (4) @(negedge clk);
        total++;
        if (Data_out !== 8'h05) begin
            bad++;
            $display("FAIL wrap_data2 got=%h want=05", Data_out);
        end
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (Xfer_done) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wrap_done got=timeout want=done");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        Xfer_addr = 18'h00030;
        Xfer_len = 8'd1;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (AddrBus_out == 32'h2000_0002) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_mid_brdy got=timeout want=BRDY");
        end
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        d0 = done_cnt;
        total++;
        if ({Bgnt, Xfer_busy, Xfer_done, Data_oe, Addr_oe} !== 5'b0 ||
            AddrBus_out !== 32'h0 || Data_out !== 8'h0) begin
            bad++;
            $display("FAIL rst_mid_outs got=%b %h %h want=0",
                     {Bgnt, Xfer_busy, Xfer_done, Data_oe, Addr_oe}, AddrBus_out, Data_out);
        end
        repeat (30) @(negedge clk);
        total++;
        if (done_cnt !== d0 || Addr_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort got=%0d want=0", done_cnt - d0);
        end
    endtask

    // Breq held high with a 3-byte copy; Breq dips one cycle per round
    task automatic test_arbitration;
        bit ok;
        Breq = 1'b1;
        Xfer_addr = 18'h00040;
        Xfer_len = 8'd3;
        Xfer_start = 1'b1;
        @(negedge clk);
        Xfer_start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                if (Bgnt) ok = 1;
                else @(negedge clk);
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL arb_ext[%0d] got=timeout want=Bgnt", r);
            end
            repeat (2) @(negedge clk);
            Breq = 1'b0;
            @(negedge clk);
            Breq = 1'b1;
            @(negedge clk);
`ifdef XFER_RR_ARB_EN
            total++;
            if (Addr_oe !== 1'b1 || Bgnt !== 1'b0) begin
                bad++;
                $display("FAIL arb_rr_byte[%0d] got=%b%b want=10", r, Addr_oe, Bgnt);
            end
`else
            total++;
            if (Bgnt !== 1'b1 || Addr_oe !== 1'b0 || Xfer_busy !== 1'b1) begin
                bad++;
                $display("FAIL arb_fixed[%0d] got=%b%b%b want=101", r, Bgnt, Addr_oe, Xfer_busy);
            end
`endif
        end
        Breq = 1'b0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!Xfer_busy && !Bgnt) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL arb_finish got=timeout want=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_uart_wait();
        test_breq_boundary();
        test_wrap();
        test_reset_mid();
        test_arbitration();
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL bgnt_addr_overlap got=%0d want=0", overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
